// File: rtl/kt_uart_pkg.sv
// Shared types and constants for the Knight-side UART command link.
//   FRAME_BITS   : start + 8 data + stop
//   DEF_BAUD_DIV : clocks per bit at 50 MHz / 19200 baud
package kt_uart_pkg;

   localparam int unsigned FRAME_BITS   = 10;
   localparam int unsigned DEF_BAUD_DIV = 2604;

   typedef enum logic {RX_IDLE, RX_BUSY}  rx_state_t;
   typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
   typedef enum logic {WAIT_HI, WAIT_LO}  asm_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-flop synchroniser, falling-edge start detect, mid-bit sampling.
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   i_rx      : serial input, idle high, asynchronous to clk
//   rx_byte   : last assembled data byte (valid while rx_vld is high)
//   rx_vld    : one-cycle pulse at a stop-bit sample of 1
//   rx_ferr   : one-cycle pulse at a stop-bit sample of 0 (byte discarded)
module uart_rx_byte
   import kt_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_rx,
   output logic [7:0] rx_byte,
   output logic       rx_vld,
   output logic       rx_ferr
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
   localparam logic [3:0]       LAST_BIT  = 4'(FRAME_BITS - 1);

   logic             r_sync1, r_sync2, r_sync_prev;
   rx_state_t        r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic [3:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]       r_shift, w_shift_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1     <= 1'b1;
         r_sync2     <= 1'b1;
         r_sync_prev <= 1'b1;
         r_state     <= RX_IDLE;
         r_cnt       <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
      end else begin
         r_sync1     <= i_rx;
         r_sync2     <= r_sync1;
         r_sync_prev <= r_sync2;
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_shift     <= w_shift_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      rx_vld        = 1'b0;
      rx_ferr       = 1'b0;
      case (r_state)
         RX_IDLE: begin
            if (r_sync_prev && !r_sync2) begin
               w_state_nxt   = RX_BUSY;
               w_cnt_nxt     = HALF_LOAD;
               w_bit_cnt_nxt = '0;
            end
         end
         RX_BUSY: begin
            if (r_cnt == '0) begin
               // Mid-bit sample: reload on terminal count so the period is exactly BAUD_DIV
               w_cnt_nxt     = BIT_LOAD;
               w_bit_cnt_nxt = r_bit_cnt + 4'd1;
               if (r_bit_cnt == 4'd0) begin
                  // Start bit read back high: treat as a glitch and rearm
                  if (r_sync2) w_state_nxt = RX_IDLE;
               end else if (r_bit_cnt == LAST_BIT) begin
                  w_state_nxt = RX_IDLE;
                  rx_vld      = r_sync2;
                  rx_ferr     = !r_sync2;
               end else begin
                  w_shift_nxt = {r_sync2, r_shift[7:1]};
               end
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end
         default: w_state_nxt = RX_IDLE;
      endcase
   end

   assign rx_byte = r_shift;

endmodule

// File: rtl/cmd_uart_wrapper.sv
// Knight-side UART command link: assembles two received bytes into a 16-bit command and
// serialises an 8-bit response back out. RX and TX run independently (full duplex).
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   RX / TX     : serial in / out, both idle high
//   cmd         : last complete command {high byte, low byte}
//   cmd_rdy     : level, new command valid; cleared by clr_cmd_rdy or a new high byte
//   clr_cmd_rdy : consumer acknowledge
//   resp, trmt  : response byte and one-cycle transmit request
//   tx_done     : level, last response fully shifted out
module cmd_uart_wrapper
   import kt_uart_pkg::*;
#(
   parameter int unsigned BAUD_DIV = DEF_BAUD_DIV
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX,
   output logic        TX,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   input  logic        clr_cmd_rdy,
   input  logic [7:0]  resp,
   input  logic        trmt,
   output logic        tx_done
);

   localparam int unsigned CNT_W = $clog2(BAUD_DIV + 1);
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(BAUD_DIV - 1);
   localparam logic [3:0]       LAST_BIT = 4'(FRAME_BITS - 1);

   logic [7:0] w_rx_byte;
   logic       w_rx_vld;
   logic       w_rx_ferr;

   uart_rx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_rx (
      .clk     (clk),
      .rst     (rst),
      .i_rx    (RX),
      .rx_byte (w_rx_byte),
      .rx_vld  (w_rx_vld),
      .rx_ferr (w_rx_ferr)
   );

   // Command assembly
   asm_state_t  r_asm_state, w_asm_state_nxt;
   logic [7:0]  r_hi, w_hi_nxt;
   logic [15:0] r_cmd, w_cmd_nxt;
   logic        r_cmd_rdy, w_cmd_rdy_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_asm_state <= WAIT_HI;
         r_hi        <= '0;
         r_cmd       <= '0;
         r_cmd_rdy   <= 1'b0;
      end else begin
         r_asm_state <= w_asm_state_nxt;
         r_hi        <= w_hi_nxt;
         r_cmd       <= w_cmd_nxt;
         r_cmd_rdy   <= w_cmd_rdy_nxt;
      end
   end

   always_comb begin
      w_asm_state_nxt = r_asm_state;
      w_hi_nxt        = r_hi;
      w_cmd_nxt       = r_cmd;
      w_cmd_rdy_nxt   = clr_cmd_rdy ? 1'b0 : r_cmd_rdy;
      case (r_asm_state)
         WAIT_HI: begin
            if (w_rx_vld) begin
               w_hi_nxt        = w_rx_byte;
               w_cmd_rdy_nxt   = 1'b0;
               w_asm_state_nxt = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (w_rx_vld) begin
               // Overrides a simultaneous clr_cmd_rdy: the set wins
               w_cmd_nxt       = {r_hi, w_rx_byte};
               w_cmd_rdy_nxt   = 1'b1;
               w_asm_state_nxt = WAIT_HI;
            end else if (w_rx_ferr) begin
               w_asm_state_nxt = WAIT_HI;
            end
         end
         default: w_asm_state_nxt = WAIT_HI;
      endcase
   end

   assign cmd     = r_cmd;
   assign cmd_rdy = r_cmd_rdy;

   // Response transmitter
   tx_state_t                 r_tx_state, w_tx_state_nxt;
   logic [FRAME_BITS-1:0]     r_tx_shift, w_tx_shift_nxt;
   logic [CNT_W-1:0]          r_tx_cnt, w_tx_cnt_nxt;
   logic [3:0]                r_tx_bit, w_tx_bit_nxt;
   logic                      r_tx_done, w_tx_done_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_state <= TX_IDLE;
         r_tx_shift <= '1;
         r_tx_cnt   <= '0;
         r_tx_bit   <= '0;
         r_tx_done  <= 1'b0;
      end else begin
         r_tx_state <= w_tx_state_nxt;
         r_tx_shift <= w_tx_shift_nxt;
         r_tx_cnt   <= w_tx_cnt_nxt;
         r_tx_bit   <= w_tx_bit_nxt;
         r_tx_done  <= w_tx_done_nxt;
      end
   end

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      w_tx_shift_nxt = r_tx_shift;
      w_tx_cnt_nxt   = r_tx_cnt;
      w_tx_bit_nxt   = r_tx_bit;
      w_tx_done_nxt  = r_tx_done;
      case (r_tx_state)
         TX_IDLE: begin
            if (trmt) begin
               w_tx_shift_nxt = {1'b1, resp, 1'b0};
               w_tx_cnt_nxt   = BIT_LOAD;
               w_tx_bit_nxt   = '0;
               w_tx_done_nxt  = 1'b0;
               w_tx_state_nxt = TX_SHIFT;
            end
         end
         TX_SHIFT: begin
            if (r_tx_cnt == '0) begin
               // Shift in ones so the line rests high once the frame is out
               w_tx_shift_nxt = {1'b1, r_tx_shift[FRAME_BITS-1:1]};
               w_tx_cnt_nxt   = BIT_LOAD;
               w_tx_bit_nxt   = r_tx_bit + 4'd1;
               if (r_tx_bit == LAST_BIT) begin
                  w_tx_state_nxt = TX_IDLE;
                  w_tx_done_nxt  = 1'b1;
               end
            end else begin
               w_tx_cnt_nxt = r_tx_cnt - 1'b1;
            end
         end
         default: w_tx_state_nxt = TX_IDLE;
      endcase
   end

   assign TX      = r_tx_shift[0];
   assign tx_done = r_tx_done;

endmodule
